// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control decoder: CTRL codes, function-field
// values, AluOp classes and the multi-cycle sequencer state type.
package alu_ctrl_pkg;

  localparam logic [2:0] CTRL_ADD = 3'd0;
  localparam logic [2:0] CTRL_SUB = 3'd1;
  localparam logic [2:0] CTRL_AND = 3'd2;
  localparam logic [2:0] CTRL_OR  = 3'd3;
  localparam logic [2:0] CTRL_SLT = 3'd4;
  localparam logic [2:0] CTRL_XOR = 3'd5;
  localparam logic [2:0] CTRL_MUL = 3'd6;
  localparam logic [2:0] CTRL_DIV = 3'd7;

  localparam logic [3:0] FUN_AND = 4'b0000;
  localparam logic [3:0] FUN_OR  = 4'b0001;
  localparam logic [3:0] FUN_ADD = 4'b0010;
  localparam logic [3:0] FUN_XOR = 4'b0011;
  localparam logic [3:0] FUN_SUB = 4'b0110;
  localparam logic [3:0] FUN_SLT = 4'b0111;
  localparam logic [3:0] FUN_MUL = 4'b1000;
  localparam logic [3:0] FUN_DIV = 4'b1001;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FUN = 2'b10;
  localparam logic [1:0] ALUOP_IMM = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mc_state_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of {AluOp, AluFun} into an ALU control code, an
// illegal flag, and multi-cycle classification (lat_sel: 0 = MUL, 1 = DIV).
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
#(
  parameter int FUN_W = 4
) (
  input  logic [1:0]       alu_op,
  input  logic [FUN_W-1:0] alu_fun,
  output logic [2:0]       ctrl,
  output logic             illegal,
  output logic             is_mc,
  output logic             lat_sel
);

  // Padding lets the upper-bit check and the 4-bit field work for any FUN_W.
  logic [FUN_W+3:0] fun_ext;
  logic [3:0]       fun4;
  logic             upper_nz;

  assign fun_ext  = {4'b0000, alu_fun};
  assign fun4     = fun_ext[3:0];
  assign upper_nz = |(fun_ext >> 4);

  always_comb begin
    ctrl    = CTRL_ADD;
    illegal = 1'b0;
    is_mc   = 1'b0;
    lat_sel = 1'b0;
    case (alu_op)
      ALUOP_ADD: ctrl = CTRL_ADD;
      ALUOP_SUB: ctrl = CTRL_SUB;
      ALUOP_FUN: begin
        if (upper_nz) begin
          illegal = 1'b1;
        end else begin
          case (fun4)
            FUN_AND: ctrl = CTRL_AND;
            FUN_OR:  ctrl = CTRL_OR;
            FUN_ADD: ctrl = CTRL_ADD;
            FUN_XOR: ctrl = CTRL_XOR;
            FUN_SUB: ctrl = CTRL_SUB;
            FUN_SLT: ctrl = CTRL_SLT;
            FUN_MUL: begin ctrl = CTRL_MUL; is_mc = 1'b1; end
            FUN_DIV: begin ctrl = CTRL_DIV; is_mc = 1'b1; lat_sel = 1'b1; end
            default: illegal = 1'b1;
          endcase
        end
      end
      default: begin
        case (fun4[1:0])
          2'b00:   ctrl = CTRL_AND;
          2'b01:   ctrl = CTRL_OR;
          2'b10:   ctrl = CTRL_XOR;
          default: ctrl = CTRL_SLT;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_mc.sv
// Registered ALU control decode at ID/EX with a MUL/DIV occupancy sequencer
// that raises a stall request for the op's latency.
//   state | meaning
//   IDLE  | no multi-cycle op in EX
//   RUN   | MUL/DIV executing, mc_busy asserted, counter running down
//   DONE  | final EX cycle of MUL/DIV, mc_done asserted, new capture allowed
module alu_ctrl_mc
  import alu_ctrl_pkg::*;
#(
  parameter int FUN_W   = 4,
  parameter int CTRL_W  = 3,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [1:0]        AluOp,
  input  logic [FUN_W-1:0]  AluFun,
  input  logic              in_valid,
  input  logic              flush,
  input  logic              ex_stall,
  output logic [CTRL_W-1:0] CTRL_OP,
  output logic              ctrl_valid,
  output logic              illegal,
  output logic              mc_busy,
  output logic              mc_done
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 2);

  logic [2:0]       dec_ctrl;
  logic             dec_illegal;
  logic             dec_is_mc;
  logic             dec_lat_sel;
  mc_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             capture;
  logic             start;
  logic [CNT_W-1:0] load_cnt;
  logic             load_done;

  alu_ctrl_dec #(.FUN_W(FUN_W)) u_dec (
    .alu_op  (AluOp),
    .alu_fun (AluFun),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .is_mc   (dec_is_mc),
    .lat_sel (dec_lat_sel)
  );

  assign capture   = in_valid & (state != ST_RUN) & ~ex_stall;
  assign start     = capture & dec_is_mc & ~dec_illegal;
  assign load_cnt  = dec_lat_sel ? DIV_CNT : MUL_CNT;
  // A two-cycle op has no RUN phase: straight to DONE.
  assign load_done = dec_lat_sel ? (DIV_LAT == 2) : (MUL_LAT == 2);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (flush) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (!ex_stall) begin
      case (state)
        ST_RUN: begin
          if (cnt == '0) state_nxt = ST_DONE;
          else           cnt_nxt   = cnt - 1'b1;
        end
        default: begin
          if (start) begin
            state_nxt = load_done ? ST_DONE : ST_RUN;
            cnt_nxt   = load_done ? '0 : load_cnt;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    mc_busy = (state == ST_RUN);
    mc_done = (state == ST_DONE);
  end

  // CTRL_OP holds through a multi-cycle op because capture is blocked in RUN.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CTRL_OP    <= '0;
      ctrl_valid <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      ctrl_valid <= 1'b0;
      illegal    <= 1'b0;
    end else if (!ex_stall) begin
      if (capture) begin
        CTRL_OP    <= CTRL_W'(dec_ctrl);
        ctrl_valid <= 1'b1;
        illegal    <= dec_illegal;
      end else if (state != ST_RUN) begin
        ctrl_valid <= 1'b0;
        illegal    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mc.sv
// Self-checking bench for alu_ctrl_mc: occupancy-count reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_alu_ctrl_mc;

  localparam int M_LAT = 3;
  localparam int D_LAT = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] AluOp = 2'b00;
  logic [3:0] AluFun = 4'b0000;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       ex_stall = 1'b0;
  logic [2:0] CTRL_OP;
  logic       ctrl_valid, illegal, mc_busy, mc_done;

  int vectors = 0;
  int miscompares = 0;

  alu_ctrl_mc #(.FUN_W(4), .CTRL_W(3), .MUL_LAT(M_LAT), .DIV_LAT(D_LAT)) dut (
    .CLK(CLK), .RST(RST), .AluOp(AluOp), .AluFun(AluFun), .in_valid(in_valid),
    .flush(flush), .ex_stall(ex_stall), .CTRL_OP(CTRL_OP), .ctrl_valid(ctrl_valid),
    .illegal(illegal), .mc_busy(mc_busy), .mc_done(mc_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the opcode tables; lat=0 means single-cycle.
  function automatic void ref_dec(input logic [1:0] op, input logic [3:0] fun,
                                  output int c, output bit il, output int lat);
    logic [1:0] lo;
    lo = fun[1:0];
    c = 0; il = 1'b0; lat = 0;
    if (op == 2'd0) c = 0;
    else if (op == 2'd1) c = 1;
    else if (op == 2'd3) c = (lo == 2'd0) ? 2 : (lo == 2'd1) ? 3 : (lo == 2'd2) ? 5 : 4;
    else begin
      case (fun)
        4'd0: c = 2;
        4'd1: c = 3;
        4'd2: c = 0;
        4'd3: c = 5;
        4'd6: c = 1;
        4'd7: c = 4;
        4'd8: begin c = 6; lat = M_LAT; end
        4'd9: begin c = 7; lat = D_LAT; end
        default: begin c = 0; il = 1'b1; end
      endcase
    end
  endfunction

  // Model state: rem = EX cycles still owed by the current op, including this one.
  int m_ctrl = 0;
  bit m_valid = 0;
  bit m_ill = 0;
  int m_rem = 0;

  always @(posedge CLK or negedge RST) begin
    int c, lat;
    bit il;
    if (!RST) begin
      m_ctrl = 0; m_valid = 0; m_ill = 0; m_rem = 0;
    end else if (flush) begin
      m_valid = 0; m_ill = 0; m_rem = 0;
    end else if (!ex_stall) begin
      if (in_valid && !(m_rem > 1)) begin
        ref_dec(AluOp, AluFun, c, il, lat);
        m_ctrl = c; m_valid = 1; m_ill = il; m_rem = il ? 0 : lat;
      end else if (m_rem > 1) begin
        m_rem = m_rem - 1;
      end else begin
        m_valid = 0; m_ill = 0; m_rem = 0;
      end
    end
  end

  always @(posedge CLK) begin
    #1;
    chk("ctrl_valid", int'(ctrl_valid), int'(m_valid));
    chk("illegal", int'(illegal), int'(m_ill));
    chk("mc_busy", int'(mc_busy), int'(m_rem > 1));
    chk("mc_done", int'(mc_done), int'(m_rem == 1));
    if (m_valid) chk("CTRL_OP", int'(CTRL_OP), m_ctrl);
  end

  task automatic issue(input logic [1:0] op, input logic [3:0] fun);
    @(negedge CLK);
    AluOp = op; AluFun = fun; in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  initial begin
    int n, busy_cnt, c, lat;
    bit il;

    // Pin the reference decode itself against hand values.
    ref_dec(2'b10, 4'b0111, c, il, lat); chk("model_slt", c, 4);
    ref_dec(2'b11, 4'b0010, c, il, lat); chk("model_imm_xor", c, 5);
    ref_dec(2'b10, 4'b1001, c, il, lat); chk("model_div_lat", lat, 8);
    ref_dec(2'b10, 4'b1111, c, il, lat); chk("model_illegal", int'(il), 1);

    #12;
    chk("rst_ctrl_op", int'(CTRL_OP), 0);
    chk("rst_valid", int'(ctrl_valid), 0);
    chk("rst_busy", int'(mc_busy), 0);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK);

    issue(2'b10, 4'b0111);
    chk("slt_op", int'(CTRL_OP), 4);
    chk("slt_valid", int'(ctrl_valid), 1);
    chk("slt_illegal", int'(illegal), 0);
    @(negedge CLK);
    chk("slt_bubble", int'(ctrl_valid), 0);

    // MUL with in_valid held high through busy: ADD only captured in DONE cycle.
    @(negedge CLK);
    AluOp = 2'b10; AluFun = 4'b1000; in_valid = 1'b1;
    @(negedge CLK);
    AluOp = 2'b00; AluFun = 4'b0000;
    chk("mul_busy1", int'(mc_busy), 1);
    chk("mul_op1", int'(CTRL_OP), 6);
    @(negedge CLK);
    chk("mul_busy2", int'(mc_busy), 1);
    chk("mul_op2", int'(CTRL_OP), 6);
    @(negedge CLK);
    chk("mul_done", int'(mc_done), 1);
    chk("mul_op3", int'(CTRL_OP), 6);
    chk("mul_busy3", int'(mc_busy), 0);
    @(negedge CLK);
    in_valid = 1'b0;
    chk("mul_next_op", int'(CTRL_OP), 0);
    chk("mul_next_valid", int'(ctrl_valid), 1);
    chk("mul_next_done", int'(mc_done), 0);
    @(negedge CLK);

    // DIV with a 2-cycle stall mid-RUN.
    issue(2'b10, 4'b1001);
    n = 0; busy_cnt = 0;
    while (!mc_done && n < 40) begin
      if (mc_busy) busy_cnt++;
      if (n == 2) ex_stall = 1'b1;
      if (n == 4) ex_stall = 1'b0;
      @(negedge CLK);
      n++;
    end
    chk("div_stall_timeout", int'(n < 40), 1);
    chk("div_stall_busy_cycles", busy_cnt, 9);
    chk("div_stall_done_cycle", n, 9);
    chk("div_stall_op", int'(CTRL_OP), 7);
    @(negedge CLK);
    chk("div_stall_after", int'(mc_done), 0);

    // DIV flushed on its 3rd busy cycle.
    issue(2'b10, 4'b1001);
    @(negedge CLK);
    @(negedge CLK);
    chk("div_flush_pre", int'(mc_busy), 1);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    chk("div_flush_busy", int'(mc_busy), 0);
    chk("div_flush_valid", int'(ctrl_valid), 0);
    busy_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      busy_cnt += int'(mc_done) + int'(mc_busy);
    end
    chk("div_flush_no_done", busy_cnt, 0);

    issue(2'b10, 4'b1111);
    chk("ill_op", int'(CTRL_OP), 0);
    chk("ill_flag", int'(illegal), 1);
    chk("ill_busy", int'(mc_busy), 0);
    issue(2'b11, 4'b0010);
    chk("imm_xor", int'(CTRL_OP), 5);
    chk("imm_xor_ill", int'(illegal), 0);

    // Back-to-back sweep of every decode entry; the model checks each cycle.
    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 16; f++) begin
        @(negedge CLK);
        AluOp = 2'(op); AluFun = 4'(f); in_valid = 1'b1;
        n = 0;
        while (mc_busy && n < 20) begin @(negedge CLK); n++; end
      end
    end
    @(negedge CLK);
    in_valid = 1'b0;
    repeat (D_LAT + 2) @(negedge CLK);

    // Async reset between edges mid-MUL.
    issue(2'b10, 4'b1000);
    chk("rstmid_pre_busy", int'(mc_busy), 1);
    #2 RST = 1'b0;
    #1;
    chk("rstmid_busy", int'(mc_busy), 0);
    chk("rstmid_valid", int'(ctrl_valid), 0);
    chk("rstmid_op", int'(CTRL_OP), 0);
    chk("rstmid_done", int'(mc_done), 0);
    @(negedge CLK); RST = 1'b1;
    issue(2'b00, 4'b0101);
    chk("post_rst_op", int'(CTRL_OP), 0);
    chk("post_rst_valid", int'(ctrl_valid), 1);
    @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_mc.md
Name: alu_ctrl_mc

Overview:
Parametrised, registered successor to the combinational ALU control decoder in the 5-stage pipeline. It decodes AluOp/AluFun into a wider CTRL_OP at the ID/EX boundary and adds an illegal-function flag. It also sequences multi-cycle MUL/DIV ops, raising a stall request to the hazard unit for the op's latency. It sits between the main control unit (ID) and the ALU (EX).

Parameters:
FUN_W, 4, width of AluFun
CTRL_W, 3, width of CTRL_OP (min 3)
MUL_LAT, 3, total EX cycles for MUL (min 2)
DIV_LAT, 8, total EX cycles for DIV (min 2)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-low reset
AluOp  in  2  ALU op class from main control
AluFun  in  FUN_W  function field (R-type funct / imm sub-op)
in_valid  in  1  ID stage holds a valid instruction
flush  in  1  synchronous kill of the EX-stage op
ex_stall  in  1  downstream freeze
CTRL_OP  out  CTRL_W  registered ALU operation select
ctrl_valid  out  1  CTRL_OP is valid this cycle
illegal  out  1  registered: undefined AluOp/AluFun combination
mc_busy  out  1  stall request to hazard unit (multi-cycle op in progress)
mc_done  out  1  one-cycle pulse, final cycle of a MUL/DIV

Behaviour:
- One clock, CLK. Reset is asynchronous and active-low on RST. Reset values: CTRL_OP=0 (ADD), ctrl_valid=0, illegal=0, mc_busy=0, mc_done=0, FSM=IDLE, counter=0.
- CTRL codes (shared package): ADD=0, SUB=1, AND=2, OR=3, SLT=4, XOR=5, MUL=6, DIV=7. Codes are zero-extended to CTRL_W.
- Decode (combinational, then registered):
  - AluOp 00 -> ADD.
  - AluOp 01 -> SUB.
  - AluOp 10 -> AluFun: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT, 1000 MUL, 1001 DIV. Any other value -> ADD with illegal=1. Upper bits beyond 4 must be 0, else illegal.
  - AluOp 11 -> immediate logic on AluFun[1:0]: 00 AND, 01 OR, 10 XOR, 11 SLT.
- Latency: inputs are sampled at edge N when in_valid & ~mc_busy & ~ex_stall. CTRL_OP, ctrl_valid and illegal are valid after edge N (cycle N+1). If the capture condition fails, ctrl_valid=0 next cycle (bubble), unless held by ex_stall.
- FSM states: IDLE, RUN, DONE.
  - IDLE: capturing MUL/DIV -> RUN, counter=LAT-2. If LAT=2, go directly to DONE.
  - RUN: counter decrements each cycle. At counter 0 -> DONE.
  - DONE: mc_done=1 for one cycle, then IDLE. A new op may be captured in the DONE cycle.
- mc_busy = (state==RUN), registered. Total EX occupancy is LAT cycles: busy for LAT-1 cycles, done in the last. CTRL_OP and ctrl_valid are held constant throughout.
- While mc_busy=1, in_valid is ignored; the hazard unit holds ID.
- ex_stall=1 freezes every register: outputs, FSM and counter. An mc_done pulse is held and extended while stalled.
- flush (priority over ex_stall and capture): next edge sets ctrl_valid=0, illegal=0, state=IDLE, counter=0, mc_busy=0, mc_done=0. A flush in the DONE cycle suppresses nothing further.
- illegal ops never start the FSM.
- Async reset mid-op returns to IDLE immediately.

Decomposition:
- Package alu_ctrl_pkg: CTRL_* code localparams, FUN_* function-field constants, AluOp class constants, FSM state enum.
- Sub-module alu_ctrl_dec: pure combinational decode of {AluOp, AluFun} -> {ctrl, illegal, is_mc, lat_sel}. The top holds the pipeline register, FSM and counter.

Test Plan:
- Reset, then AluOp=10, AluFun=0111, in_valid=1 for one cycle -> next cycle CTRL_OP=4, ctrl_valid=1, illegal=0; following cycle ctrl_valid=0.
- AluOp=10, AluFun=1000 (MUL), MUL_LAT=3 -> mc_busy high 2 cycles, mc_done high in the 3rd; CTRL_OP=6 held all 3 cycles. in_valid held high during busy is not captured until the DONE cycle.
- DIV (DIV_LAT=8) with ex_stall pulsed 2 cycles mid-RUN -> busy lasts 9 cycles total, mc_done after cycle 10, counter frozen during stall.
- DIV with flush asserted on the 3rd busy cycle -> next cycle mc_busy=0, ctrl_valid=0, no mc_done pulse.
- AluOp=10, AluFun=1111 -> CTRL_OP=0, illegal=1, mc_busy stays 0. AluOp=11, AluFun=0010 -> CTRL_OP=5.
- RST driven low asynchronously mid-MUL (between edges) -> all outputs 0 immediately. After release, the first valid ADD decodes normally.
